// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width, DVI control tokens and the alignment FSM states.
// Used by the deserializer and the TMDS encoder.
package tmds_pkg;

   localparam int TMDS_WORD_W = 10;

   localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
   localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
   localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
   localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2
   } tmds_state_e;

   function automatic logic is_ctrl_token(input logic [TMDS_WORD_W-1:0] sym);
      logic hit;
      case (sym)
         CTRL_TOKEN_00, CTRL_TOKEN_01, CTRL_TOKEN_10, CTRL_TOKEN_11: hit = 1'b1;
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/tmds_lane_shift.sv
// One TMDS lane: LSB-first 10-bit shift register with symbol capture on load.
// The captured symbol includes the bit arriving on the load edge itself.
module tmds_lane_shift
   import tmds_pkg::*;
(
   input  logic                   clk_TMDS,
   input  logic                   rst_n,
   input  logic                   serial_bit,
   input  logic                   load,
   output logic [TMDS_WORD_W-1:0] symbol
);

   logic [TMDS_WORD_W-1:0] sr_r;
   logic [TMDS_WORD_W-1:0] sr_next_s;
   logic [TMDS_WORD_W-1:0] symbol_r;

   assign sr_next_s = {serial_bit, sr_r[TMDS_WORD_W-1:1]};
   assign symbol    = symbol_r;

   // Shift every bit clock; snapshot the completed word on load
   always_ff @(posedge clk_TMDS or negedge rst_n) begin
      if (!rst_n) begin
         sr_r     <= 10'd0;
         symbol_r <= 10'd0;
      end else begin
         sr_r <= sr_next_s;
         if (load) begin
            symbol_r <= sr_next_s;
         end
      end
   end

endmodule

// File: rtl/tmds_deserializer.sv
// TMDS 1:10 deserializer with control-token word alignment via bit-slip.
// Optional lock-loss counter: define TMDS_DESER_REALIGN_CNT_EN.
module tmds_deserializer
   import tmds_pkg::*;
#(
   parameter int LOCK_COUNT    = 4,
   parameter int SEARCH_WORDS  = 1024,
   parameter int TIMEOUT_WORDS = 65536
) (
   input  logic                   clk_TMDS,
   input  logic                   rst_n,
   input  logic [2:0]             TMDS_serial,
   output logic [TMDS_WORD_W-1:0] TMDS_red,
   output logic [TMDS_WORD_W-1:0] TMDS_green,
   output logic [TMDS_WORD_W-1:0] TMDS_blue,
   output logic                   word_valid,
   output logic                   locked,
   output logic [15:0]            realign_count
);

   localparam int WC_W = $clog2(SEARCH_WORDS + 1);
   localparam int CC_W = $clog2(LOCK_COUNT + 1);
   localparam int TC_W = $clog2(TIMEOUT_WORDS + 1);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(SEARCH_WORDS - 1);
   localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
   localparam logic [CC_W-1:0] CC_LAST = CC_W'(LOCK_COUNT - 1);
   localparam logic [CC_W-1:0] CC_ONE  = CC_W'(1);
   localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT_WORDS - 1);
   localparam logic [TC_W-1:0] TC_ONE  = TC_W'(1);

   logic [3:0]             phase_r, phase_next_s;
   logic                   load_s, load_d_r, slip_s, token_s;
   logic [TMDS_WORD_W-1:0] red_s, green_s, blue_s;
   logic [TMDS_WORD_W-1:0] red_r, green_r, blue_r;
   logic                   word_valid_r, locked_r;
   tmds_state_e            state_r, state_next_s;
   logic [WC_W-1:0]        word_cnt_r, word_cnt_next_s;
   logic [CC_W-1:0]        conf_cnt_r, conf_cnt_next_s;
   logic [TC_W-1:0]        to_cnt_r, to_cnt_next_s;

   assign load_s = (phase_r == 4'd9);

   tmds_lane_shift u_lane_red   (.clk_TMDS(clk_TMDS), .rst_n(rst_n), .serial_bit(TMDS_serial[2]), .load(load_s), .symbol(red_s));
   tmds_lane_shift u_lane_green (.clk_TMDS(clk_TMDS), .rst_n(rst_n), .serial_bit(TMDS_serial[1]), .load(load_s), .symbol(green_s));
   tmds_lane_shift u_lane_blue  (.clk_TMDS(clk_TMDS), .rst_n(rst_n), .serial_bit(TMDS_serial[0]), .load(load_s), .symbol(blue_s));

   // Word phase: a slip holds the count for one cycle, pushing the boundary one bit later
   always_comb begin
      phase_next_s = phase_r;
      if (slip_s) begin
         phase_next_s = phase_r;
      end else if (load_s) begin
         phase_next_s = 4'd0;
      end else begin
         phase_next_s = phase_r + 4'd1;
      end
   end

   // Phase counter and registered symbol/strobe outputs
   always_ff @(posedge clk_TMDS or negedge rst_n) begin
      if (!rst_n) begin
         phase_r      <= 4'd0;
         load_d_r     <= 1'b0;
         word_valid_r <= 1'b0;
         red_r        <= 10'd0;
         green_r      <= 10'd0;
         blue_r       <= 10'd0;
      end else begin
         phase_r      <= phase_next_s;
         load_d_r     <= load_s;
         word_valid_r <= load_d_r;
         if (load_d_r) begin
            red_r   <= red_s;
            green_r <= green_s;
            blue_r  <= blue_s;
         end
      end
   end

   assign token_s = is_ctrl_token(blue_r);

   // Alignment FSM: acts once per strobe; a token always beats a pending slip
   always_comb begin
      state_next_s    = state_r;
      word_cnt_next_s = word_cnt_r;
      conf_cnt_next_s = conf_cnt_r;
      to_cnt_next_s   = to_cnt_r;
      slip_s          = 1'b0;
      if (word_valid_r) begin
         case (state_r)
            SEARCH: begin
               if (token_s) begin
                  state_next_s    = CONFIRM;
                  conf_cnt_next_s = CC_ONE;
                  word_cnt_next_s = {WC_W{1'b0}};
               end else if (word_cnt_r == WC_LAST) begin
                  slip_s          = 1'b1;
                  word_cnt_next_s = {WC_W{1'b0}};
               end else begin
                  word_cnt_next_s = (word_cnt_r == {WC_W{1'b1}}) ? word_cnt_r : word_cnt_r + WC_ONE;
               end
            end
            CONFIRM: begin
               if (!token_s) begin
                  state_next_s    = SEARCH;
                  conf_cnt_next_s = {CC_W{1'b0}};
                  word_cnt_next_s = {WC_W{1'b0}};
               end else if (conf_cnt_r == CC_LAST) begin
                  state_next_s    = LOCKED;
                  conf_cnt_next_s = {CC_W{1'b0}};
                  to_cnt_next_s   = {TC_W{1'b0}};
               end else begin
                  conf_cnt_next_s = (conf_cnt_r == {CC_W{1'b1}}) ? conf_cnt_r : conf_cnt_r + CC_ONE;
               end
            end
            LOCKED: begin
               if (token_s) begin
                  to_cnt_next_s = {TC_W{1'b0}};
               end else if (to_cnt_r == TC_LAST) begin
                  state_next_s    = SEARCH;
                  to_cnt_next_s   = {TC_W{1'b0}};
                  word_cnt_next_s = {WC_W{1'b0}};
               end else begin
                  to_cnt_next_s = (to_cnt_r == {TC_W{1'b1}}) ? to_cnt_r : to_cnt_r + TC_ONE;
               end
            end
            default: begin
               state_next_s    = SEARCH;
               word_cnt_next_s = {WC_W{1'b0}};
               conf_cnt_next_s = {CC_W{1'b0}};
               to_cnt_next_s   = {TC_W{1'b0}};
            end
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // FSM state, counters and the registered lock flag
   always_ff @(posedge clk_TMDS or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= SEARCH;
         word_cnt_r <= {WC_W{1'b0}};
         conf_cnt_r <= {CC_W{1'b0}};
         to_cnt_r   <= {TC_W{1'b0}};
         locked_r   <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         word_cnt_r <= word_cnt_next_s;
         conf_cnt_r <= conf_cnt_next_s;
         to_cnt_r   <= to_cnt_next_s;
         locked_r   <= (state_next_s == LOCKED);
      end
   end

`ifdef TMDS_DESER_REALIGN_CNT_EN
   logic        realign_inc_s;
   logic [15:0] realign_cnt_r;

   assign realign_inc_s = word_valid_r && (state_r == LOCKED) && !token_s && (to_cnt_r == TC_LAST);

   // Saturating count of lock losses
   always_ff @(posedge clk_TMDS or negedge rst_n) begin
      if (!rst_n) begin
         realign_cnt_r <= 16'd0;
      end else if (realign_inc_s && (realign_cnt_r != 16'hFFFF)) begin
         realign_cnt_r <= realign_cnt_r + 16'd1;
      end
   end

   assign realign_count = realign_cnt_r;
`else
   assign realign_count = 16'd0;
`endif

   assign TMDS_red   = red_r;
   assign TMDS_green = green_r;
   assign TMDS_blue  = blue_r;
   assign word_valid = word_valid_r;
   assign locked     = locked_r;

endmodule

// File: tb/tb_tmds_deserializer.sv
// Randomized bench for tmds_deserializer against a word-level reference model.
module tb_tmds_deserializer;

   localparam int LOCK_N    = 4;
   localparam int SEARCH_N  = 8;
   localparam int TIMEOUT_N = 16;
   localparam int HMASK     = 8191;
   localparam logic [9:0] TOK0 = 10'b1101010100;
   localparam logic [9:0] TOK1 = 10'b0010101011;
   localparam logic [9:0] TOK2 = 10'b0101010100;
   localparam logic [9:0] TOK3 = 10'b1010101011;
`ifdef TMDS_DESER_REALIGN_CNT_EN
   localparam int EXP_REALIGN_1 = 1;
`else
   localparam int EXP_REALIGN_1 = 0;
`endif
   localparam int K_TOK = 0, K_DATA = 1, K_1F0 = 2, K_MIX = 3;

   logic       clk_TMDS = 1'b0;
   logic       rst_n    = 1'b1;
   logic [2:0] TMDS_serial = 3'd0;
   logic [9:0] TMDS_red, TMDS_green, TMDS_blue;
   logic       word_valid, locked;
   logic [15:0] realign_count;

   always #5 clk_TMDS = ~clk_TMDS;

   tmds_deserializer #(
      .LOCK_COUNT(LOCK_N), .SEARCH_WORDS(SEARCH_N), .TIMEOUT_WORDS(TIMEOUT_N)
   ) dut (
      .clk_TMDS(clk_TMDS), .rst_n(rst_n), .TMDS_serial(TMDS_serial),
      .TMDS_red(TMDS_red), .TMDS_green(TMDS_green), .TMDS_blue(TMDS_blue),
      .word_valid(word_valid), .locked(locked), .realign_count(realign_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [2:0] txq [$];
   logic [2:0] hist [0:HMASK];
   int t = 0;

   // reference model: word boundaries, token streak and miss counting
   int   m_next_end, m_last_end, m_streak, m_miss, m_realign;
   bit   m_locked;
   int   p1_t, p2_t;
   logic [9:0] p1_r, p1_g, p1_b;
   bit   p2_locked;
   int   p2_realign;
   logic exp_wv, exp_locked;
   logic [9:0] exp_r, exp_g, exp_b;
   int   exp_realign;

   // observed DUT events
   int wv_total, elevens, last_wv_t, rise_wv, fall_wv;
   logic locked_q;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, obs, exp, t);
      end
   endtask

   function automatic bit is_tok(input logic [9:0] v);
      return v inside {TOK0, TOK1, TOK2, TOK3};
   endfunction

   function automatic logic [9:0] rand_data();
      logic [9:0] v;
      v = 10'($urandom);
      while (is_tok(v)) v = 10'($urandom);
      return v;
   endfunction

   task automatic model_word();
      logic [9:0] s [3];
      bit tok, slip;
      for (int ln = 0; ln < 3; ln++)
         for (int i = 0; i < 10; i++)
            s[ln][i] = hist[(t - 9 + i) & HMASK][ln];
      p1_t = t + 1; p1_r = s[2]; p1_g = s[1]; p1_b = s[0];
      tok = is_tok(s[0]);
      slip = 1'b0;
      if (tok) begin
         m_miss = 0;
         if (!m_locked) begin
            m_streak++;
            if (m_streak == LOCK_N) begin m_locked = 1'b1; m_streak = 0; end
         end
      end else if (m_locked) begin
         m_miss++;
         if (m_miss == TIMEOUT_N) begin
            m_locked = 1'b0; m_miss = 0;
`ifdef TMDS_DESER_REALIGN_CNT_EN
            if (m_realign < 65535) m_realign++;
`endif
         end
      end else if (m_streak > 0) begin
         m_streak = 0; m_miss = 0;
      end else begin
         m_miss++;
         if (m_miss == SEARCH_N) begin slip = 1'b1; m_miss = 0; end
      end
      p2_t = t + 2; p2_locked = m_locked; p2_realign = m_realign;
      m_last_end = t;
      m_next_end = t + (slip ? 11 : 10);
   endtask

   task automatic model_step();
      exp_wv = 1'b0;
      if (t == p1_t) begin exp_wv = 1'b1; exp_r = p1_r; exp_g = p1_g; exp_b = p1_b; end
      if (t == p2_t) begin exp_locked = p2_locked; exp_realign = p2_realign; end
      if (t == m_next_end) model_word();
   endtask

   task automatic tick();
      logic [2:0] b;
      b = (txq.size() > 0) ? txq.pop_front() : 3'($urandom);
      TMDS_serial = b;
      @(posedge clk_TMDS);
      t++;
      hist[t & HMASK] = b;
      model_step();
      @(negedge clk_TMDS);
      check_val("word_valid", 32'(word_valid), 32'(exp_wv));
      check_val("locked", 32'(locked), 32'(exp_locked));
      check_val("realign_count", 32'(realign_count), 32'(exp_realign));
      check_val("red", 32'(TMDS_red), 32'(exp_r));
      check_val("green", 32'(TMDS_green), 32'(exp_g));
      check_val("blue", 32'(TMDS_blue), 32'(exp_b));
      if (word_valid) begin
         wv_total++;
         if (last_wv_t >= 0 && (t - last_wv_t) == 11) elevens++;
         last_wv_t = t;
      end
      if (locked && !locked_q) rise_wv = wv_total;
      if (!locked && locked_q) fall_wv = wv_total;
      locked_q = locked;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_val("rst_red", 32'(TMDS_red), 32'd0);
      check_val("rst_green", 32'(TMDS_green), 32'd0);
      check_val("rst_blue", 32'(TMDS_blue), 32'd0);
      check_val("rst_word_valid", 32'(word_valid), 32'd0);
      check_val("rst_locked", 32'(locked), 32'd0);
      check_val("rst_realign", 32'(realign_count), 32'd0);
      @(posedge clk_TMDS);
      @(negedge clk_TMDS);
      rst_n = 1'b1;
      exp_wv = 1'b0; exp_locked = 1'b0; exp_realign = 0;
      exp_r = 10'd0; exp_g = 10'd0; exp_b = 10'd0;
      p1_t = -1; p2_t = -1;
      m_locked = 1'b0; m_streak = 0; m_miss = 0; m_realign = 0;
      m_next_end = t + 10; m_last_end = t;
      txq.delete();
      wv_total = 0; elevens = 0; last_wv_t = -1; rise_wv = -1; fall_wv = -1;
      locked_q = 1'b0;
   endtask

   task automatic push_word(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b, input int skip);
      for (int i = skip; i < 10; i++) txq.push_back({r[i], g[i], b[i]});
   endtask

   task automatic push_kind(input int kind, input int skip);
      logic [9:0] r, g, b;
      r = 10'($urandom); g = 10'($urandom);
      case (kind)
         K_TOK:   begin r = 10'h2AA; g = 10'h155; b = TOK0; end
         K_DATA:  b = rand_data();
         K_1F0:   b = 10'h1F0;
         default: begin
            case ($urandom_range(0, 7))
               0: b = TOK0;
               1: b = TOK1;
               2: b = TOK2;
               3: b = TOK3;
               default: b = rand_data();
            endcase
         end
      endcase
      push_word(r, g, b, skip);
   endtask

   task automatic send_words(input int n, input int kind);
      for (int i = 0; i < n; i++) push_kind(kind, 0);
      while (txq.size() > 0) tick();
   endtask

   initial begin
      bit found;
      #2;
      do_reset();

      // aligned loopback: lock on the 4th token, then timeout on 16 data words
      send_words(6, K_TOK);
      check_val("lock_after_4_tokens", 32'(rise_wv), 32'd4);
      send_words(16, K_DATA);
      send_words(1, K_DATA);
      check_val("lock_drop_after_16", 32'(fall_wv), 32'd22);
      check_val("realign_after_timeout", 32'(realign_count), 32'(EXP_REALIGN_1));

      // 3 tokens then a data word in CONFIRM: back to SEARCH, streak cleared, no slip
      send_words(3, K_TOK);
      send_words(1, K_1F0);
      send_words(6, K_TOK);
      check_val("relock_after_broken_confirm", 32'(rise_wv), 32'd31);
      check_val("no_slip_when_aligned", 32'(elevens), 32'd0);

      // reset at phase 5 while locked
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         if (m_locked && (t - m_last_end) == 5) found = 1'b1;
         else begin
            if (txq.size() < 10) push_kind(K_TOK, 0);
            tick();
         end
      end
      check_val("reached_phase5_locked", 32'(found), 32'd1);
      check_val("locked_before_reset", 32'(locked), 32'd1);
      do_reset();
      send_words(6, K_TOK);
      check_val("relock_after_reset", 32'(rise_wv), 32'd4);

      // 3-bit offset: 7 slips before alignment, then lock
      do_reset();
      push_kind(K_TOK, 3);
      send_words(66, K_TOK);
      check_val("slips_for_offset3", 32'(elevens), 32'd7);
      check_val("lock_after_slips", 32'(rise_wv), 32'd60);
      check_val("red_after_lock", 32'(TMDS_red), 32'h2AA);
      check_val("green_after_lock", 32'(TMDS_green), 32'h155);
      check_val("blue_after_lock", 32'(TMDS_blue), 32'(TOK0));

      // random offset and mixed traffic
      push_kind(K_MIX, $urandom_range(1, 9));
      send_words(60, K_MIX);
      send_words(70, K_TOK);
      send_words(20, K_DATA);
      send_words(80, K_MIX);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
